// File: rtl/jt51_wrq_pkg.sv
// jt51_wrq_pkg
// Shared types for the jt51 host write queue: bus FSM state encoding,
// the queued register-write entry and the position of the busy flag in
// the jt51 dout byte.
package jt51_wrq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_GAP       = 3'd2,
        ST_DATA      = 3'd3,
        ST_GUARD     = 3'd4,
        ST_BUSY_WAIT = 3'd5
    } wrq_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wrq_entry_t;

    localparam int BUSY_BIT = 7;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// jt51_wrq_fifo
// Synchronous FIFO of wrq_entry_t, 2^AW entries deep.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: push request and entry; dropped (o_drop) when full
//   i_pop          : pop request; ignored when empty
//   o_head         : entry at the read pointer (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy, all registered-state derived
//   o_drop         : single-cycle pulse when a push is refused
// Full is taken from the occupancy before this cycle's pop, so a push
// that meets a pop while full is still refused.
module jt51_wrq_fifo
    import jt51_wrq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  wrq_entry_t  i_wdata,
    input  logic        i_pop,
    output wrq_entry_t  o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count,
    output logic        o_drop
);
    localparam int DEPTH = 1 << AW;

    wrq_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Occupancy never exceeds DEPTH, so the top count bit alone means full.
    assign o_full    = r_count[AW];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_drop    = i_push && o_full;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/jt51_wrq.sv
// jt51_wrq
// Host-side register write queue in front of the jt51 core. Host writes
// land in a FIFO at up to one per clock; a bus FSM replays each one as an
// address phase (a0=0) then a data phase (a0=1) and waits for busy
// (chip_dout[7]) to clear before starting the next write.
// Ports:
//   clk, rst_n      : clock shared with jt51, asynchronous active-low reset
//   cen_p1          : jt51 clock enable; the bus FSM advances only when high
//   host_wr/addr/data : push one register write
//   host_clr        : clears the sticky overflow/timeout flags
//   host_full, host_empty, count : FIFO status
//   overflow, timeout : sticky error flags (set beats clear)
//   idle            : registered; FIFO empty and FSM in IDLE
//   cs_n, wr_n, a0, din : registered jt51 bus outputs
//   chip_dout       : jt51 dout, bit 7 is busy
module jt51_wrq
    import jt51_wrq_pkg::*;
#(
    parameter int AW       = 4,
    parameter int HOLD     = 2,
    parameter int GUARD    = 4,
    parameter int BUSY_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen_p1,
    input  logic        host_wr,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_data,
    input  logic        host_clr,
    output logic        host_full,
    output logic        host_empty,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        timeout,
    output logic        idle,
    output logic        cs_n,
    output logic        wr_n,
    output logic        a0,
    output logic [7:0]  din,
    input  logic [7:0]  chip_dout
);
    // The tick counter is loaded with (duration - 1) on state entry and the
    // state is left on the tick where it reads zero.
    localparam logic [7:0] HOLD_LD  = 8'(HOLD - 1);
    localparam logic [7:0] GUARD_LD = 8'(GUARD - 1);
    localparam logic [7:0] BUSY_LD  = 8'(BUSY_MAX - 1);

    wrq_state_t r_state;
    wrq_state_t w_state_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    wrq_entry_t r_hold;
    wrq_entry_t w_head;
    wrq_entry_t w_push_entry;
    logic       w_pop;
    logic       w_empty;
    logic       w_drop;
    logic       w_to_set;
    logic       w_busy;
    logic       w_unused_dout;
    logic       r_cs_n;
    logic       r_a0;
    logic [7:0] r_din;
    logic       r_ovf;
    logic       r_to;
    logic       r_idle;

    assign w_busy        = chip_dout[BUSY_BIT];
    assign w_unused_dout = ^chip_dout[6:0];
    assign w_push_entry  = '{addr: host_addr, data: host_data};

    jt51_wrq_fifo #(.AW(AW)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (host_wr),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (host_full),
        .o_empty (w_empty),
        .o_count (count),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pop      = 1'b0;
        w_to_set   = 1'b0;
        if (cen_p1) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_state_nx = ST_ADDR;
                        w_cnt_nx   = HOLD_LD;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nx = ST_GAP;
                        w_cnt_nx   = 8'd0;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    w_state_nx = ST_DATA;
                    w_cnt_nx   = HOLD_LD;
                end
                ST_DATA: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nx = ST_GUARD;
                        w_cnt_nx   = GUARD_LD;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                ST_GUARD: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nx = ST_BUSY_WAIT;
                        w_cnt_nx   = BUSY_LD;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                ST_BUSY_WAIT: begin
                    if (!w_busy) begin
                        // Chain straight into the next write when one is queued.
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_state_nx = ST_ADDR;
                            w_cnt_nx   = HOLD_LD;
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = 8'd0;
                        end
                    end else if (r_cnt == 8'd0) begin
                        // Give up on busy; the held entry counts as delivered.
                        w_to_set   = 1'b1;
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 8'd0;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    // Bus outputs are registered from the next state, so they only move on
    // cen_p1 ticks and a0/din stay put for the whole low phase. The ADDR
    // phase takes its address straight from the FIFO head on the pop tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_hold  <= '0;
            r_cs_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_din   <= 8'd0;
        end else if (cen_p1) begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_pop) r_hold <= w_head;
            case (w_state_nx)
                ST_ADDR: begin
                    r_cs_n <= 1'b0;
                    r_a0   <= 1'b0;
                    r_din  <= w_pop ? w_head.addr : r_hold.addr;
                end
                ST_DATA: begin
                    r_cs_n <= 1'b0;
                    r_a0   <= 1'b1;
                    r_din  <= r_hold.data;
                end
                default: r_cs_n <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_to   <= 1'b0;
            r_idle <= 1'b1;
        end else begin
            if (w_drop)        r_ovf <= 1'b1;
            else if (host_clr) r_ovf <= 1'b0;
            if (w_to_set)      r_to  <= 1'b1;
            else if (host_clr) r_to  <= 1'b0;
            r_idle <= (r_state == ST_IDLE) && w_empty;
        end
    end

    assign host_empty = w_empty;
    assign overflow   = r_ovf;
    assign timeout    = r_to;
    assign idle       = r_idle;
    // jt51 samples a write on cs_n and wr_n together, so one flop drives both.
    assign cs_n       = r_cs_n;
    assign wr_n       = r_cs_n;
    assign a0         = r_a0;
    assign din        = r_din;

endmodule
